// File: rtl/nioshello_rom_loader_if.sv
// nioshello_rom_loader_if: byte stream in, niosHello s1 write port and loader status out
interface nioshello_rom_loader_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              cpu_reset_req;
  logic              busy;
  logic              done;
  logic              error;
  modport master (
    input  in_data, in_valid,
    output in_ready, mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
    output cpu_reset_req, busy, done, error
  );
  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
    input  cpu_reset_req, busy, done, error
  );
endinterface

// File: rtl/nioshello_rom_loader.sv
// nioshello_rom_loader: framed byte stream to little-endian word writes, holding the CPU in reset while loading.
// Defining LOADER_CHECKSUM_EN adds a trailing 8-bit checksum byte gating DONE vs ERR.
module nioshello_rom_loader #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_WORD = '0,
  parameter logic [7:0]        SYNC_BYTE = 8'hA5
) (
  input logic clk,
  input logic reset_n,
  nioshello_rom_loader_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, CNT_LO, CNT_HI, DATA, WRITE,
`ifdef LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE, ERR
  } state_t;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t TAIL = CSUM;
  logic [7:0] sum;
`else
  localparam state_t TAIL = DONE;
`endif
  state_t            state, nxt;
  logic              acc;
  logic [7:0]        cnt_lo;
  logic [15:0]       cnt;
  logic [15:0]       remain;
  logic [1:0]        idx;
  logic [31:0]       data;
  logic [ADDR_W-1:0] addr;
  logic              hold, done_q, err_q;
  assign acc = bus.in_valid & bus.in_ready;
  assign cnt = {bus.in_data, cnt_lo};
  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (acc && bus.in_data == SYNC_BYTE) nxt = CNT_LO;
      CNT_LO: if (acc) nxt = CNT_HI;
      CNT_HI: if (acc) nxt = cnt == 16'd0 ? TAIL : DATA;
      DATA:   if (acc && idx == 2'd3) nxt = WRITE;
      WRITE:  nxt = remain == 16'd1 ? TAIL : DATA;
`ifdef LOADER_CHECKSUM_EN
      CSUM:   if (acc) nxt = 8'(sum + bus.in_data) == 8'd0 ? DONE : ERR;
`endif
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_lo <= '0;
      remain <= '0;
      idx    <= '0;
      data   <= '0;
      addr   <= '0;
      hold   <= 1'b1;
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum    <= '0;
`endif
    end else begin
      if (state == IDLE && nxt == CNT_LO) begin
        hold   <= 1'b1;
        done_q <= 1'b0;
        err_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum    <= '0;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      if (acc && (state == CNT_LO || state == CNT_HI || state == DATA)) sum <= sum + bus.in_data;
`endif
      if (acc && state == CNT_LO) cnt_lo <= bus.in_data;
      if (acc && state == CNT_HI) begin
        remain <= cnt;
        addr   <= BASE_WORD;
        idx    <= '0;
      end
      if (acc && state == DATA) begin
        data[{idx, 3'b000} +: 8] <= bus.in_data;
        idx <= idx + 2'd1;
      end
      // address advances after the write cycle so it is stable while mem_write is high
      if (state == WRITE) begin
        addr   <= addr + 1'b1;
        remain <= remain - 16'd1;
      end
      if (nxt == DONE) begin
        hold   <= 1'b0;
        done_q <= 1'b1;
      end
      if (nxt == ERR) err_q <= 1'b1;
    end
  end
  assign bus.in_ready       = reset_n && state != WRITE && state != DONE && state != ERR;
  assign bus.mem_write      = state == WRITE;
  assign bus.mem_chipselect = state == WRITE;
  assign bus.mem_byteenable = {4{state == WRITE}};
  assign bus.mem_address    = addr;
  assign bus.mem_writedata  = data;
  assign bus.cpu_reset_req  = hold;
  assign bus.busy           = state != IDLE;
  assign bus.done           = done_q;
  assign bus.error          = err_q;
endmodule

// File: tb/tb_nioshello_rom_loader.sv
// tb_nioshello_rom_loader: directed frames into two loaders (BASE_WORD 0 and 16'hFFFF) with a write scoreboard.
module tb_nioshello_rom_loader;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  wr_t  qa[$];
  wr_t  qb[$];
  always #5 clk = ~clk;
  nioshello_rom_loader_if #(.ADDR_W(16)) a ();
  nioshello_rom_loader_if #(.ADDR_W(16)) b ();
  assign b.in_data  = a.in_data;
  assign b.in_valid = a.in_valid;
  nioshello_rom_loader #(.ADDR_W(16), .BASE_WORD(16'h0000), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .bus(a.master));
  nioshello_rom_loader #(.ADDR_W(16), .BASE_WORD(16'hFFFF), .SYNC_BYTE(8'hA5)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .bus(b.master));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // scoreboard monitor: every write cycle must match the oldest expected write
  always @(negedge clk) begin
    if (a.mem_write === 1'b1) begin
      chk("a_ready_in_write", 64'(a.in_ready), 64'd0);
      chk("a_byteenable", 64'(a.mem_byteenable), 64'hF);
      chk("a_chipselect", 64'(a.mem_chipselect), 64'd1);
      if (qa.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL a_unexpected_write: got %h@%h expected none", a.mem_writedata, a.mem_address);
      end else chk("a_write", 64'({a.mem_address, a.mem_writedata}), 64'(qa.pop_front()));
    end
    if (b.mem_write === 1'b1) begin
      chk("b_byteenable", 64'(b.mem_byteenable), 64'hF);
      if (qb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b_unexpected_write: got %h@%h expected none", b.mem_writedata, b.mem_address);
      end else chk("b_write_wrap", 64'({b.mem_address, b.mem_writedata}), 64'(qb.pop_front()));
    end
  end
  task automatic send(input logic [7:0] v, input int gap);
    int n = 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    a.in_data  = v;
    a.in_valid = 1'b1;
    while (a.in_ready !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 40) chk("ready_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    a.in_valid = 1'b0;
  endtask
  task automatic run_frame(input int nw, input logic [31:0] w0, input logic [31:0] w1,
                           input bit bursty, input logic [7:0] cerr);
    logic [7:0]  fb[$];
    logic [7:0]  s;
    logic [31:0] w;
    logic [15:0] c;
    bit          bad;
    c   = 16'(nw);
    bad = CS && cerr != 8'd0;
    fb  = '{8'hA5, c[7:0], c[15:8]};
    for (int k = 0; k < nw; k++) begin
      w = k == 0 ? w0 : w1;
      for (int j = 0; j < 4; j++) fb.push_back(w[8*j +: 8]);
      qa.push_back({16'(k), w});
      qb.push_back({16'(16'hFFFF + k), w});
    end
    if (CS) begin
      s = 8'd0;
      for (int i = 1; i < fb.size(); i++) s = s + fb[i];
      fb.push_back(8'(8'd0 - s) + cerr);
    end
    for (int i = 0; i < fb.size(); i++) begin
      send(fb[i], bursty ? int'($urandom_range(0, 7)) : 0);
      if (i == 0) begin
        chk("sync_clears_done", 64'(a.done), 64'd0);
        chk("sync_clears_error", 64'(a.error), 64'd0);
        chk("sync_busy", 64'(a.busy), 64'd1);
        chk("sync_holds_cpu", 64'(a.cpu_reset_req), 64'd1);
      end
    end
    if (nw > 0 && !CS) begin
      chk("req_during_last_write", 64'(a.cpu_reset_req), 64'd1);
      @(posedge clk);
      #1;
    end
    chk("end_ready_low", 64'(a.in_ready), 64'd0);
    chk("end_busy", 64'(a.busy), 64'd1);
    chk("end_done", 64'(a.done), 64'(!bad));
    chk("end_error", 64'(a.error), 64'(bad));
    chk("end_cpu_reset_req", 64'(a.cpu_reset_req), 64'(bad));
    @(posedge clk);
    #1;
    chk("idle_busy", 64'(a.busy), 64'd0);
    chk("idle_ready", 64'(a.in_ready), 64'd1);
    chk("idle_done", 64'(a.done), 64'(!bad));
    chk("idle_cpu_reset_req", 64'(a.cpu_reset_req), 64'(bad));
    chk("a_writes_outstanding", 64'(qa.size()), 64'd0);
    chk("b_writes_outstanding", 64'(qb.size()), 64'd0);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 64'(a.in_ready), 64'd0);
    chk({tag, "_mem"}, 64'({a.mem_address, a.mem_writedata, a.mem_byteenable, a.mem_chipselect, a.mem_write}), 64'd0);
    chk({tag, "_cpu_reset_req"}, 64'(a.cpu_reset_req), 64'd1);
    chk({tag, "_flags"}, 64'({a.busy, a.done, a.error}), 64'd0);
    chk({tag, "_wrap_addr"}, 64'(b.mem_address), 64'd0);
  endtask
  initial begin
    a.in_data  = 8'h00;
    a.in_valid = 1'b0;
    #1 reset_n = 1'b0;
    #2 chk_reset("por");
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_ready", 64'(a.in_ready), 64'd1);
    run_frame(2, 32'h12345678, 32'hDEADBEEF, 1'b0, 8'h00);
    run_frame(2, 32'h12345678, 32'hDEADBEEF, 1'b1, 8'h00);
    run_frame(0, 32'h0, 32'h0, 1'b0, 8'h00);
    run_frame(1, 32'h01020304, 32'h0, 1'b0, 8'h00);
    if (CS) begin
      run_frame(1, 32'h01020304, 32'h0, 1'b0, 8'hFF);
      run_frame(1, 32'h01020304, 32'h0, 1'b1, 8'h00);
    end
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'h78, 0);
    send(8'h56, 0);
    #2 reset_n = 1'b0;
    #1 chk_reset("midframe");
    @(posedge clk);
    #1 reset_n = 1'b1;
    send(8'h00, 0);
    chk("stray00_busy", 64'(a.busy), 64'd0);
    send(8'h3C, 0);
    chk("stray3c_busy", 64'(a.busy), 64'd0);
    chk("stray_cpu_reset_req", 64'(a.cpu_reset_req), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("final_a_queue", 64'(qa.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
